// File: rtl/sequenciador_consultas_if.sv
// Host-side and core-side signal bundle for the query scheduler.
// slave is the scheduler's view; master is the host/core/testbench view.
interface sequenciador_consultas_if #(
    parameter int unsigned ADDR_WIDTH = 10
);
    // Query handshake
    logic                  req_valid_in;
    logic                  req_ready_out;
    logic [ADDR_WIDTH-1:0] req_fonte_in;
    logic [ADDR_WIDTH-1:0] req_destino_in;
    // Obstacle write handshake
    logic                  obs_wr_valid_in;
    logic                  obs_wr_ready_out;
    logic [ADDR_WIDTH-1:0] obs_wr_addr_in;
    logic                  obs_wr_data_in;
    // Core start and endpoints
    logic                  top_wr_fonte_out;
    logic [ADDR_WIDTH-1:0] top_addr_fonte_out;
    logic [ADDR_WIDTH-1:0] top_addr_destino_out;
    // Core obstacle map write
    logic                  obstaculos_wr_enable_out;
    logic [ADDR_WIDTH-1:0] obstaculos_wr_addr_out;
    logic                  obstaculos_wr_data_out;
    // Path nodes from the core
    logic                  gma_pronto_in;
    logic [ADDR_WIDTH-1:0] gma_read_data_in;
    // Result stream
    logic                  res_valid_out;
    logic                  res_ready_in;
    logic [ADDR_WIDTH-1:0] res_data_out;
    logic                  res_last_out;
    logic                  res_erro_out;
    logic                  ocupado_out;

    modport slave (
        input  req_valid_in, req_fonte_in, req_destino_in,
        input  obs_wr_valid_in, obs_wr_addr_in, obs_wr_data_in,
        input  gma_pronto_in, gma_read_data_in, res_ready_in,
        output req_ready_out, obs_wr_ready_out,
        output top_wr_fonte_out, top_addr_fonte_out, top_addr_destino_out,
        output obstaculos_wr_enable_out, obstaculos_wr_addr_out, obstaculos_wr_data_out,
        output res_valid_out, res_data_out, res_last_out, res_erro_out, ocupado_out
    );

    modport master (
        output req_valid_in, req_fonte_in, req_destino_in,
        output obs_wr_valid_in, obs_wr_addr_in, obs_wr_data_in,
        output gma_pronto_in, gma_read_data_in, res_ready_in,
        input  req_ready_out, obs_wr_ready_out,
        input  top_wr_fonte_out, top_addr_fonte_out, top_addr_destino_out,
        input  obstaculos_wr_enable_out, obstaculos_wr_addr_out, obstaculos_wr_data_out,
        input  res_valid_out, res_data_out, res_last_out, res_erro_out, ocupado_out
    );
endinterface

// File: rtl/sequenciador_consultas.sv
// Query scheduler for the path-finding core: arbitrates obstacle writes against
// queries in IDLE, starts the core, and streams path nodes into a result FIFO
// terminated by a word carrying fonte, last=1 and the error flag.
module sequenciador_consultas #(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned RES_DEPTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input logic                    clk,
    input logic                    rst,
    sequenciador_consultas_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(RES_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned WORD_W = ADDR_WIDTH + 2;
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RES_DEPTH);

    typedef enum logic [1:0] {StIdle, StIniciar, StAguarda, StFim} estado_t;

    estado_t               estado_q;
    logic [TMR_W-1:0]      timer_q;
    logic                  overflow_q;
    logic                  erro_q;
    logic [ADDR_WIDTH-1:0] fonte_q;
    logic [ADDR_WIDTH-1:0] destino_q;
    logic                  top_wr_q;
    logic                  obs_en_q;
    logic [ADDR_WIDTH-1:0] obs_addr_q;
    logic                  obs_data_q;

    // Result FIFO storage; word layout is {last, erro, data}
    logic [WORD_W-1:0]     mem [RES_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [CNT_W-1:0]      count_q;

    logic                  full;
    logic                  empty;
    logic                  obs_acc;
    logic                  req_acc;
    logic                  node_ev;
    logic                  node_fim;
    logic                  push_req;
    logic [WORD_W-1:0]     push_word;
    logic                  push;
    logic                  pop;

    // Arbitration, node decode and FIFO push/pop selection
    always_comb begin
        full      = (count_q == CNT_FULL);
        empty     = (count_q == '0);
        obs_acc   = (estado_q == StIdle) && bus.obs_wr_valid_in;
        req_acc   = (estado_q == StIdle) && bus.req_valid_in && !bus.obs_wr_valid_in;
        node_ev   = (estado_q == StAguarda) && bus.gma_pronto_in;
        node_fim  = node_ev && (bus.gma_read_data_in == fonte_q);
        push_req  = 1'b0;
        push_word = '0;
        if (node_ev && !node_fim) begin
            push_req  = 1'b1;
            push_word = {1'b0, 1'b0, bus.gma_read_data_in};
        end else if (estado_q == StFim) begin
            push_req  = 1'b1;
            push_word = {1'b1, erro_q, fonte_q};
        end
        // A full FIFO refuses the push even if a pop happens in the same cycle
        push = push_req && !full;
        pop  = !empty && bus.res_ready_in;
    end

    // Scheduler FSM with registered core-facing outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q   <= StIdle;
            timer_q    <= '0;
            overflow_q <= 1'b0;
            erro_q     <= 1'b0;
            fonte_q    <= '0;
            destino_q  <= '0;
            top_wr_q   <= 1'b0;
            obs_en_q   <= 1'b0;
            obs_addr_q <= '0;
            obs_data_q <= 1'b0;
        end else begin
            top_wr_q <= 1'b0;
            obs_en_q <= obs_acc;
            if (obs_acc) begin
                obs_addr_q <= bus.obs_wr_addr_in;
                obs_data_q <= bus.obs_wr_data_in;
            end
            unique case (estado_q)
                StIdle: begin
                    if (req_acc) begin
                        fonte_q   <= bus.req_fonte_in;
                        destino_q <= bus.req_destino_in;
                        top_wr_q  <= 1'b1;
                        estado_q  <= StIniciar;
                    end
                end
                StIniciar: begin
                    timer_q    <= '0;
                    overflow_q <= 1'b0;
                    estado_q   <= StAguarda;
                end
                StAguarda: begin
                    // A node in the expiry cycle takes precedence over the timeout
                    if (bus.gma_pronto_in) begin
                        if (node_fim) begin
                            erro_q   <= overflow_q;
                            estado_q <= StFim;
                        end else begin
                            timer_q <= '0;
                            if (full) begin
                                overflow_q <= 1'b1;
                            end
                        end
                    end else if (timer_q == TMR_MAX) begin
                        erro_q   <= 1'b1;
                        estado_q <= StFim;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                StFim: begin
                    if (!full) begin
                        estado_q <= StIdle;
                    end
                end
                default: estado_q <= StIdle;
            endcase
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage write; contents need no reset since reads are gated by empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_word;
        end
    end

    assign bus.req_ready_out            = (estado_q == StIdle) && !bus.obs_wr_valid_in;
    assign bus.obs_wr_ready_out         = (estado_q == StIdle);
    assign bus.ocupado_out              = (estado_q != StIdle);
    assign bus.top_wr_fonte_out         = top_wr_q;
    assign bus.top_addr_fonte_out       = fonte_q;
    assign bus.top_addr_destino_out     = destino_q;
    assign bus.obstaculos_wr_enable_out = obs_en_q;
    assign bus.obstaculos_wr_addr_out   = obs_addr_q;
    assign bus.obstaculos_wr_data_out   = obs_data_q;
    assign bus.res_valid_out            = !empty;
    assign bus.res_data_out             = empty ? '0 : mem[rd_ptr_q][ADDR_WIDTH-1:0];
    assign bus.res_erro_out             = empty ? 1'b0 : mem[rd_ptr_q][ADDR_WIDTH];
    assign bus.res_last_out             = empty ? 1'b0 : mem[rd_ptr_q][ADDR_WIDTH+1];
endmodule

// File: tb/tb_sequenciador_consultas.sv
// Scoreboard bench for sequenciador_consultas: stimulus pushes expected result
// words, a monitor pops and compares each word the DUT hands over.
module tb_sequenciador_consultas;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sequenciador_consultas_if #(.ADDR_WIDTH(AW)) bus ();

    sequenciador_consultas #(
        .ADDR_WIDTH    (AW),
        .RES_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    int obs_pulses = 0;
    logic [AW+1:0] exp_q[$];
    logic [AW+1:0] mon_exp;
    logic [AW+1:0] mon_got;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: compare every handed-over result word against the scoreboard
    always @(negedge clk) begin
        if (!rst && bus.res_valid_out && bus.res_ready_in) begin
            mon_got = {bus.res_last_out, bus.res_erro_out, bus.res_data_out};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL res_stream: got word %0h, required none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_err++;
                    $display("FAIL res_stream: got %0h, required %0h", mon_got, mon_exp);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.obstaculos_wr_enable_out) obs_pulses++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input bit last, input bit erro, input int data);
        exp_q.push_back({last, erro, AW'(data)});
    endtask

    // Returns one cycle after the accepting edge, #1 past the clock
    task automatic send_query(input int f, input int d);
        bit ok = 0;
        bus.req_fonte_in   = AW'(f);
        bus.req_destino_in = AW'(d);
        bus.req_valid_in   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.req_ready_out) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid_in = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL query_accept: got no ready, required ready");
        end
    endtask

    task automatic strobe(input int n);
        bus.gma_pronto_in    = 1'b1;
        bus.gma_read_data_in = AW'(n);
        step();
        bus.gma_pronto_in = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        bit ok = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (!bus.ocupado_out && exp_q.size() == 0 && !bus.res_valid_out) begin
                ok = 1;
                break;
            end
        end
        step();
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got busy/pending %0d, required idle and drained", exp_q.size());
        end
    endtask

    initial begin
        int bad;
        int base;
        bit ok;
        bus.req_valid_in     = 1'b0;
        bus.req_fonte_in     = '0;
        bus.req_destino_in   = '0;
        bus.obs_wr_valid_in  = 1'b0;
        bus.obs_wr_addr_in   = '0;
        bus.obs_wr_data_in   = 1'b0;
        bus.gma_pronto_in    = 1'b0;
        bus.gma_read_data_in = '0;
        bus.res_ready_in     = 1'b1;

        // Reset values
        @(negedge clk);
        check("rst_ocupado", 32'(bus.ocupado_out), 0);
        check("rst_res_valid", 32'(bus.res_valid_out), 0);
        check("rst_req_ready", 32'(bus.req_ready_out), 1);
        check("rst_obs_ready", 32'(bus.obs_wr_ready_out), 1);
        check("rst_top_wr", 32'(bus.top_wr_fonte_out), 0);
        check("rst_obs_en", 32'(bus.obstaculos_wr_enable_out), 0);
        step();
        rst = 1'b0;
        step();

        // Obstacle write in IDLE
        bus.obs_wr_addr_in  = AW'(5);
        bus.obs_wr_data_in  = 1'b1;
        bus.obs_wr_valid_in = 1'b1;
        @(negedge clk);
        check("obs_ready_idle", 32'(bus.obs_wr_ready_out), 1);
        check("req_ready_blocked_by_obs", 32'(bus.req_ready_out), 0);
        step();
        bus.obs_wr_valid_in = 1'b0;
        @(negedge clk);
        check("obs_en_pulse", 32'(bus.obstaculos_wr_enable_out), 1);
        check("obs_addr", 32'(bus.obstaculos_wr_addr_out), 5);
        check("obs_data", 32'(bus.obstaculos_wr_data_out), 1);
        step();
        @(negedge clk);
        check("obs_en_single", 32'(bus.obstaculos_wr_enable_out), 0);
        step();

        // Normal query 3 -> 40
        expect_word(0, 0, 40);
        expect_word(0, 0, 22);
        expect_word(1, 0, 3);
        send_query(3, 40);
        @(negedge clk);
        check("start_strobe", 32'(bus.top_wr_fonte_out), 1);
        check("start_fonte", 32'(bus.top_addr_fonte_out), 3);
        check("start_destino", 32'(bus.top_addr_destino_out), 40);
        check("busy_iniciar", 32'(bus.ocupado_out), 1);
        step();
        @(negedge clk);
        check("start_one_cycle", 32'(bus.top_wr_fonte_out), 0);
        step();
        strobe(40);
        strobe(22);
        strobe(3);
        wait_done(50);

        // Obstacle write held off during AGUARDA, then issued once
        base = obs_pulses;
        expect_word(1, 0, 7);
        send_query(7, 9);
        step();
        bus.obs_wr_addr_in  = AW'(5);
        bus.obs_wr_data_in  = 1'b1;
        bus.obs_wr_valid_in = 1'b1;
        step();
        @(negedge clk);
        check("obs_ready_busy", 32'(bus.obs_wr_ready_out), 0);
        check("obs_en_busy", 32'(bus.obstaculos_wr_enable_out), 0);
        step();
        strobe(7);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.obs_wr_ready_out) begin
                ok = 1;
                break;
            end
        end
        check("obs_stall_released", 32'(ok), 1);
        step();
        bus.obs_wr_valid_in = 1'b0;
        @(negedge clk);
        check("obs_stalled_en", 32'(bus.obstaculos_wr_enable_out), 1);
        check("obs_stalled_addr", 32'(bus.obstaculos_wr_addr_out), 5);
        wait_done(50);
        check("obs_stalled_once", 32'(obs_pulses - base), 1);

        // Timeout: no nodes
        bus.res_ready_in = 1'b0;
        send_query(12, 50);
        bad = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.res_valid_out) bad++;
        end
        check("timeout_not_early", 32'(bad), 0);
        @(negedge clk);
        check("timeout_word_valid", 32'(bus.res_valid_out), 1);
        check("timeout_idle", 32'(bus.ocupado_out), 0);
        expect_word(1, 1, 12);
        step();
        bus.res_ready_in = 1'b1;
        wait_done(50);

        // Overflow: 6 nodes into a 4-deep FIFO, then fonte
        bus.res_ready_in = 1'b0;
        expect_word(0, 0, 60);
        expect_word(0, 0, 50);
        expect_word(0, 0, 40);
        expect_word(0, 0, 30);
        expect_word(1, 1, 1);
        send_query(1, 60);
        step();
        strobe(60);
        strobe(50);
        strobe(40);
        strobe(30);
        strobe(20);
        strobe(10);
        strobe(1);
        repeat (4) step();
        @(negedge clk);
        check("ovf_fim_stalled", 32'(bus.ocupado_out), 1);
        check("ovf_head_data", 32'(bus.res_data_out), 60);
        step();
        bus.res_ready_in = 1'b1;
        wait_done(50);

        // Simultaneous query and obstacle: obstacle first
        bus.req_fonte_in    = AW'(2);
        bus.req_destino_in  = AW'(33);
        bus.req_valid_in    = 1'b1;
        bus.obs_wr_addr_in  = AW'(9);
        bus.obs_wr_data_in  = 1'b0;
        bus.obs_wr_valid_in = 1'b1;
        @(negedge clk);
        check("arb_req_ready", 32'(bus.req_ready_out), 0);
        check("arb_obs_ready", 32'(bus.obs_wr_ready_out), 1);
        step();
        bus.obs_wr_valid_in = 1'b0;
        @(negedge clk);
        check("arb_obs_en", 32'(bus.obstaculos_wr_enable_out), 1);
        check("arb_obs_addr", 32'(bus.obstaculos_wr_addr_out), 9);
        check("arb_req_ready_next", 32'(bus.req_ready_out), 1);
        step();
        bus.req_valid_in = 1'b0;
        @(negedge clk);
        check("arb_query_start", 32'(bus.top_wr_fonte_out), 1);
        check("arb_query_fonte", 32'(bus.top_addr_fonte_out), 2);
        expect_word(1, 0, 2);
        step();
        strobe(2);
        wait_done(50);

        // Reset mid-AGUARDA discards the query
        bus.res_ready_in = 1'b0;
        send_query(4, 44);
        step();
        strobe(44);
        step();
        rst = 1'b1;
        #1;
        check("midrst_ocupado", 32'(bus.ocupado_out), 0);
        check("midrst_res_valid", 32'(bus.res_valid_out), 0);
        check("midrst_req_ready", 32'(bus.req_ready_out), 1);
        check("midrst_obs_ready", 32'(bus.obs_wr_ready_out), 1);
        step();
        rst = 1'b0;
        bus.res_ready_in = 1'b1;
        repeat (12) step();
        @(negedge clk);
        check("midrst_no_word", 32'(bus.res_valid_out), 0);
        check("midrst_still_idle", 32'(bus.ocupado_out), 0);
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/sequenciador_consultas.md
# sequenciador_consultas

Front-end scheduler for the path-finding core. It accepts path queries (fonte, destino) and host obstacle writes, and arbitrates them so the obstacle map changes only between queries. It pulses the core's start strobe and streams the resulting path nodes into a result FIFO with valid/ready, flagging timeout and overflow. It sits between the host interface and the core's `top_wr_fonte_in` / `obstaculos_wr_*` / `gma_*` ports.

## Interface
- `ADDR_WIDTH`, default 10: node address width.
- `RES_DEPTH`, default 16: result FIFO depth, a power of 2, at least 2.
- `TIMEOUT_CYCLES`, default 65535: maximum number of AGUARDA cycles without a node; at least 2.
- `clk`, in, 1: single clock; everything is on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req_valid_in` / `req_ready_out`, in/out, 1: query handshake.
- `req_fonte_in`, `req_destino_in`, in, ADDR_WIDTH: query endpoints.
- `obs_wr_valid_in` / `obs_wr_ready_out`, in/out, 1: obstacle-write handshake.
- `obs_wr_addr_in`, in, ADDR_WIDTH; `obs_wr_data_in`, in, 1: obstacle write address and data.
- `top_wr_fonte_out`, out, 1: one-cycle start strobe to the core.
- `top_addr_fonte_out`, `top_addr_destino_out`, out, ADDR_WIDTH: registered query endpoints.
- `obstaculos_wr_enable_out`, out, 1; `obstaculos_wr_addr_out`, out, ADDR_WIDTH; `obstaculos_wr_data_out`, out, 1: registered obstacle write to the core.
- `gma_pronto_in`, in, 1: one-cycle strobe, one per path node.
- `gma_read_data_in`, in, ADDR_WIDTH: the path node, valid while `gma_pronto_in` is high. Nodes arrive destino first and end with fonte.
- `res_valid_out` / `res_ready_in`, out/in, 1: result stream handshake.
- `res_data_out`, out, ADDR_WIDTH: path node.
- `res_last_out`, out, 1: terminal word of a query.
- `res_erro_out`, out, 1: query failed (timeout or overflow); valid on the terminal word only.
- `ocupado_out`, out, 1: high when the state is not IDLE.

## Operation
- States:
  - IDLE: accepts requests.
  - INICIAR: pulses the core.
  - AGUARDA: collects path nodes.
  - FIM: pushes the terminal word.
- IDLE arbitration, with obstacle writes taking fixed priority:
  - `obs_wr_ready_out` = (state==IDLE).
  - `req_ready_out` = (state==IDLE) & !`obs_wr_valid_in`.
- Obstacle accept (valid & ready): the next cycle drives `obstaculos_wr_enable_out`=1 with the registered addr/data. The state stays IDLE, so back-to-back writes are possible at one per cycle.
- Query accept: latch fonte/destino into `top_addr_*_out`, then go to INICIAR.
- INICIAR: `top_wr_fonte_out`=1 for exactly one cycle, then go to AGUARDA. Clear the timer and the overflow flag.
- AGUARDA, on `gma_pronto_in`:
  - Node ≠ fonte: push {last=0, erro=0, node} if the FIFO is not full; otherwise drop it and set the sticky overflow flag. Reset the timer.
  - Node == fonte: go to FIM with erro = overflow flag.
- AGUARDA, without a node:
  - Increment the timer.
  - When the timer reaches TIMEOUT_CYCLES-1, go to FIM with erro=1.
  - A node arriving in the expiry cycle wins over the timeout.
- FIM: wait until the FIFO is not full, then push {last=1, erro, data=fonte} and go to IDLE.
- Ignored inputs:
  - `gma_pronto_in` outside AGUARDA is ignored.
  - Obstacle and query requests outside IDLE are held off; they are never dropped.
- Result FIFO:
  - `res_valid_out` = !empty; pop on valid & ready.
  - Full blocks a push even when a pop happens in the same cycle.
  - Read and write pointers wrap modulo RES_DEPTH; an occupancy counter of width log2(RES_DEPTH)+1 distinguishes full from empty.
- Back-to-back queries are allowed while earlier results are still draining; order is preserved.

## Timing
- Reset values:
  - All outputs are 0 except `req_ready_out`=1 and `obs_wr_ready_out`=1.
  - State is IDLE, the FIFO is empty, and the timer and overflow flag are 0.
- Reset mid-query: return to IDLE immediately. Queued results are discarded and no terminal word is emitted.
- Query accepted at edge N:
  - `top_wr_fonte_out`=1 during cycle N+1.
  - AGUARDA from N+2.
  - The earliest next accept is the cycle after the FIM push.
- Obstacle accepted at edge N: `obstaculos_wr_enable_out`=1 during cycle N+1 only.
- Node strobe at edge M: `res_valid_out` rises at M+1 if the FIFO was empty.
- Fonte strobe at edge M: FIM during M+1, and the terminal word becomes visible from M+2 if the FIFO is not full.
- Timeout: with no nodes, FIM follows TIMEOUT_CYCLES cycles spent in AGUARDA.
- `res_*` outputs are stable while `res_valid_out` is high and `res_ready_in` is low.

## Test plan
- Reset: assert `rst` mid-AGUARDA. Required: `ocupado_out`=0, `res_valid_out`=0, both ready outputs=1 in the same cycle, and no terminal word afterwards.
- Obstacle write: addr 5, data 1, presented in IDLE. Required: one cycle of `obstaculos_wr_enable_out`, addr 5, data 1. The same write presented during AGUARDA is stalled until IDLE and then issued once.
- Normal query: fonte=3, destino=40; nodes 40, 22, 3 strobed. Required:
  - `top_wr_fonte_out` pulses one cycle after accept with 3/40 on the address outputs.
  - The stream is 40 (last 0), 22 (last 0), 3 (last 1, erro 0).
- Timeout: TIMEOUT_CYCLES=8, no nodes. Required: after 8 AGUARDA cycles, a single word {data=fonte, last=1, erro=1}, then IDLE.
- Overflow: RES_DEPTH=4, `res_ready_in`=0; 6 nodes plus fonte strobed. Required: 4 words held, FIM stalls, then after `res_ready_in`=1 the terminal word arrives with erro=1.
- Simultaneous arbitration: query and obstacle both valid in IDLE. Required: the obstacle is accepted and `req_ready_out`=0 that cycle; the query is accepted the next cycle with `obs_wr_valid_in` low.
